bus_master_arbiter: RTL
=======================

// Module: bus_master_arbiter
// PURPOSE
//  Two-master arbiter in front of bus_controller: shares the single system bus between the
//  CPU data port (m0) and a second master (m1, DMA/debug loader). Sequences one access at a
//  time, forwards addr/ctrl/wdata, then returns the synchronous read data (data_mem BRAM,
//  GPIO, seg_led registers) to the owning master after a fixed latency.
// PARAMETERS
//  RD_LATENCY  1       cycles from the issue cycle to bus_rdata valid (>=1)
//  RR_EN       1       1: round-robin; 0: fixed priority, m0 always wins
//  CTRL_IDLE   3'b000  bus_ctrl value driven when no access is issued
// PORTS
//  clk         in   1   system clock (clk_50m domain)
//  rst         in   1   asynchronous reset, active-high
//  m0_req      in   1   m0 access request; m0_addr/m0_ctrl/m0_we/m0_wdata held stable until m0_gnt
//  m0_we       in   1   1 = write, 0 = read
//  m0_addr     in   32  byte address
//  m0_ctrl     in   3   access type (size/sign), passed through unchanged
//  m0_wdata    in   32  write data
//  m0_gnt      out  1   1-cycle pulse: m0 access is on the bus this cycle
//  m0_rvalid   out  1   1-cycle pulse: m0_rdata valid
//  m0_rdata    out  32  read data
//  m1_*        --   --  identical set for master 1
//  bus_addr    out  32  to bus_controller cpu_addr
//  bus_ctrl    out  3   to bus_controller cpu_ctrl
//  bus_we      out  1   write qualifier to bus_controller
//  bus_wdata   out  32  to bus_controller cpu_wdata
//  bus_rdata   in   32  from bus_controller cpu_rdata
//  owner       out  1   master owning current/last transaction (debug)
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, RWAIT, RDATA. One transaction in flight; no pipelining.
//  - IDLE: on clock edge with any req high, select winner, register its addr/ctrl/we/wdata
//    onto bus_*, set owner, go ISSUE. No req: stay IDLE, bus_ctrl=CTRL_IDLE, bus_we=0.
//  - Arbitration (RR_EN=1): one req -> that master; both -> master != last granted.
//    last_gnt resets to 1, so m0 wins the first contention. RR_EN=0: m0 always wins.
//  - ISSUE (exactly 1 cycle): mX_gnt=1 for owner, bus_* carry the access.
//    Write -> IDLE. Read -> RDATA if RD_LATENCY==1, else RWAIT.
//    last_gnt updates to owner at the exit of ISSUE.
//  - RWAIT: down-counter loaded with RD_LATENCY-1 on entering; RWAIT lasts RD_LATENCY-1 cycles,
//    bus_ctrl=CTRL_IDLE, bus_we=0, bus_addr held. Counter reaching 0 -> RDATA.
//  - RDATA (1 cycle): mX_rvalid=1 and mX_rdata=bus_rdata for owner; -> IDLE.
//  - Read data therefore returns RD_LATENCY cycles after gnt. Non-owner rdata=0, rvalid=0.
//  - Throughput: write 2 cycles/access, read RD_LATENCY+2 cycles/access.
//  - Master must hold req through its gnt cycle. Requests are not sampled in ISSUE/RWAIT/RDATA.
//    Master may drop req in the cycle after gnt; a req still high is re-arbitrated in IDLE.
//  - Req withdrawn while in IDLE before grant: legal, no access issued.
//  - Reset (async, any state): state=IDLE, all gnt/rvalid=0, rdata=0, bus_addr=0,
//    bus_wdata=0, bus_we=0, bus_ctrl=CTRL_IDLE, owner=0, last_gnt=1, counter=0.
//    An in-flight read is discarded; no rvalid is issued after reset release.
//  - No combinational path from mX_req to any output; gnt/bus_* are registered.
//    rdata is a mux of bus_rdata.
// TESTING
//  1. m0 write addr=0x0000_0010 wdata=0xDEADBEEF, m1 idle -> m0_gnt 1 cycle after req.
//     bus_we=1 and bus_addr/wdata match in that cycle. Next access can be granted 2 cycles later.
//  2. m1 read 0x0000_0010, RD_LATENCY=1 -> m1_gnt cycle t, m1_rvalid at t+1 with 0xDEADBEEF.
//     m0_rvalid stays 0.
//  3. m0 and m1 both hold read reqs continuously, RR_EN=1 -> grants alternate m0,m1,m0,m1.
//     Each grant is spaced 3 cycles apart, and every rvalid goes to the correct owner.
//  4. Same as 3 with RR_EN=0 -> m0 granted every transaction; m1_gnt never asserted.
//  5. RD_LATENCY=3, m0 read -> m0_rvalid exactly 3 cycles after m0_gnt.
//     m1 req arriving during RWAIT is granted only after RDATA, not before.
//  6. Assert rst during RWAIT -> outputs return to reset values immediately (asynchronously).
//     No rvalid after release, and the first contended grant goes to m0.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Two-master arbiter sharing one system bus: one access in flight, registered bus drive,
// read data returned to the owning master a fixed RD_LATENCY cycles after its grant.
module bus_master_arbiter #(
    parameter int         RD_LATENCY = 1,
    parameter bit         RR_EN      = 1'b1,
    parameter logic [2:0] CTRL_IDLE  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_ctrl,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_ctrl,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [2:0]  bus_ctrl,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        owner
);

    // state | meaning
    // IDLE  | bus idle, arbitrate on any request
    // ISSUE | access on the bus, grant pulse to owner
    // RWAIT | waiting RD_LATENCY-1 cycles for read data
    // RDATA | read data returned to owner
    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RDATA} state_t;

    localparam int             CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    state_t           state;
    logic             last_gnt;
    logic [CNT_W-1:0] cnt;
    logic             sel_m1;

    // On contention round-robin hands the bus to whoever was not served last.
    always_comb begin
        if (m0_req && m1_req) begin
            sel_m1 = RR_EN ? ~last_gnt : 1'b0;
        end else begin
            sel_m1 = m1_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_ctrl  <= CTRL_IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            cnt       <= '0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    bus_we   <= 1'b0;
                    bus_ctrl <= CTRL_IDLE;
                    if (m0_req || m1_req) begin
                        owner     <= sel_m1;
                        bus_addr  <= sel_m1 ? m1_addr  : m0_addr;
                        bus_ctrl  <= sel_m1 ? m1_ctrl  : m0_ctrl;
                        bus_we    <= sel_m1 ? m1_we    : m0_we;
                        bus_wdata <= sel_m1 ? m1_wdata : m0_wdata;
                        m0_gnt    <= ~sel_m1;
                        m1_gnt    <= sel_m1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_we   <= 1'b0;
                    bus_ctrl <= CTRL_IDLE;
                    last_gnt <= owner;
                    if (bus_we) begin
                        state <= IDLE;
                    end else if (RD_LATENCY == 1) begin
                        m0_rvalid <= ~owner;
                        m1_rvalid <= owner;
                        state     <= RDATA;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        m0_rvalid <= ~owner;
                        m1_rvalid <= owner;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m0_rdata = m0_rvalid ? bus_rdata : 32'h0;
    assign m1_rdata = m1_rvalid ? bus_rdata : 32'h0;

endmodule
